// File: rtl/pingpong_tile_buffer.sv
// pingpong_tile_buffer: two-bank operand buffer between the operand loader
// and the PE array. The producer fills one bank while the consumer drains
// the other. Each bank cycles FREE -> FILL -> READY -> FREE.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   wr_valid/ready   write handshake into the current fill bank
//   wr_addr/last     entry index; wr_last commits the fill bank
//   data_in          write data
//   rd_en/rd_addr    read request on the current drain bank
//   rd_release       consumer done with the drain bank
//   rd_bank_valid    drain bank is committed (READY)
//   data_out(_valid) registered read result, 1-cycle latency
//   banks_ready      number of READY banks (0..2)
//   err_sticky       protocol violation seen since reset
//   parity_err       read parity mismatch, aligned with data_out
//
// Build option: define PINGPONG_BUF_PARITY_EN to store an even-parity bit
// per entry and check it on reads; otherwise parity_err is tied to 0.

// Storage for one bank. Reads are combinational here; the top registers them.
module pingpong_tile_bank #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rpar_err
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef PINGPONG_BUF_PARITY_EN
  // Even parity: stored bit equals XOR of data, so zeroed entries carry 0.
  logic par [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
    end else if (we) begin
      par[waddr] <= ^wdata;
    end
  end

  assign rpar_err = (^mem[raddr]) != par[raddr];
`else
  assign rpar_err = 1'b0;
`endif
endmodule

module pingpong_tile_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_last,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_bank_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [1:0]            banks_ready,
  output logic                  err_sticky,
  output logic                  parity_err
);
  typedef enum logic [1:0] {ST_FREE, ST_FILL, ST_READY} bank_st_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  bank_st_t state [2];
  logic     wr_bank, rd_bank;

  logic                       wr_acc, rd_acc, rel_acc, wr_oob, rd_oob;
  logic [1:0]                 we;
  logic [1:0][DATA_WIDTH-1:0] rdata;
  logic [1:0]                 rpar_err;

  assign wr_ready      = state[wr_bank] != ST_READY;
  assign rd_bank_valid = state[rd_bank] == ST_READY;
  assign banks_ready   = {1'b0, state[0] == ST_READY} + {1'b0, state[1] == ST_READY};

  assign wr_acc  = wr_valid & wr_ready;
  assign rd_acc  = rd_en & rd_bank_valid;
  assign rel_acc = rd_release & rd_bank_valid;
  assign wr_oob  = {1'b0, wr_addr} >= DEPTH_W;
  assign rd_oob  = {1'b0, rd_addr} >= DEPTH_W;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    // Out-of-range writes are dropped; the state transition still happens.
    assign we[b] = wr_acc & ~wr_oob & (wr_bank == 1'(b));

    pingpong_tile_bank #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .we      (we[b]),
      .waddr   (wr_addr),
      .wdata   (data_in),
      .raddr   (rd_addr),
      .rdata   (rdata[b]),
      .rpar_err(rpar_err[b])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state[0]       <= ST_FREE;
      state[1]       <= ST_FREE;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_err     <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      // Write and release never target the same bank in one cycle: a READY
      // bank blocks writes, and only READY banks can be released.
      if (wr_acc) begin
        if (wr_last) begin
          state[wr_bank] <= ST_READY;
          wr_bank        <= ~wr_bank;
        end else if (state[wr_bank] == ST_FREE) begin
          state[wr_bank] <= ST_FILL;
        end
      end
      if (rel_acc) begin
        state[rd_bank] <= ST_FREE;
        rd_bank        <= ~rd_bank;
      end

      // Read samples the pre-release bank; contents survive release anyway.
      data_out_valid <= rd_acc;
      data_out       <= (rd_acc && !rd_oob) ? rdata[rd_bank] : '0;
      parity_err     <= rd_acc & ~rd_oob & rpar_err[rd_bank];

      if ((wr_valid && !wr_ready) || (wr_acc && wr_oob) ||
          ((rd_en || rd_release) && !rd_bank_valid) || (rd_acc && rd_oob))
        err_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pingpong_tile_buffer.sv
module tb_pingpong_tile_buffer;
  logic         clk = 1'b0;
  logic         rstn;
  logic         wr_valid, wr_last, rd_en, rd_release;
  logic [1:0]   wr_addr, rd_addr;
  logic [127:0] data_in;
  logic         wr_ready, rd_bank_valid, data_out_valid, err_sticky, parity_err;
  logic [127:0] data_out;
  logic [1:0]   banks_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pingpong_tile_buffer dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_last(wr_last), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_bank_valid(rd_bank_valid), .data_out(data_out),
    .data_out_valid(data_out_valid), .banks_ready(banks_ready),
    .err_sticky(err_sticky), .parity_err(parity_err)
  );

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_last = 0; wr_addr = 0; data_in = '0;
    rd_en = 0; rd_addr = 0; rd_release = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] b, input logic last);
    wr_valid = 1; wr_addr = a; data_in = pat(b); wr_last = last;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".wr_ready"}, 128'(wr_ready), 128'd1);
    chk({tag, ".rd_bank_valid"}, 128'(rd_bank_valid), 128'd0);
    chk({tag, ".banks_ready"}, 128'(banks_ready), 128'd0);
    chk({tag, ".data_out"}, data_out, 128'd0);
    chk({tag, ".dov"}, 128'(data_out_valid), 128'd0);
    chk({tag, ".err"}, 128'(err_sticky), 128'd0);
    chk({tag, ".perr"}, 128'(parity_err), 128'd0);
  endtask

  initial begin
    logic [7:0] b1 [4];
    logic [7:0] b0 [4];
    b0[0] = 8'h11; b0[1] = 8'h22; b0[2] = 8'h33; b0[3] = 8'h44;
    b1[0] = 8'h55; b1[1] = 8'h66; b1[2] = 8'h77; b1[3] = 8'h88;

    idle();
    rstn = 0;
    #12;
    chk_reset_outs("rst");
    rstn = 1;
    tick();

    // Fill bank 0
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), b0[i], i == 3);
      chk("fill0.wr_ready", 128'(wr_ready), 128'd1);
      tick();
    end
    idle();
    chk("fill0.banks_ready", 128'(banks_ready), 128'd1);
    chk("fill0.rd_bank_valid", 128'(rd_bank_valid), 128'd1);
    chk("fill0.wr_ready_after", 128'(wr_ready), 128'd1);

    // Back-to-back reads addr 2 then 0
    rd_en = 1; rd_addr = 2;
    tick();
    chk("rd2.data", data_out, pat(8'h33));
    chk("rd2.dov", 128'(data_out_valid), 128'd1);
    chk("rd2.perr", 128'(parity_err), 128'd0);
    rd_addr = 0;
    tick();
    chk("rd0.data", data_out, pat(8'h11));
    chk("rd0.dov", 128'(data_out_valid), 128'd1);
    idle();
    tick();
    chk("rd_idle.dov", 128'(data_out_valid), 128'd0);
    chk("rd_idle.data", data_out, 128'd0);

    // Fill bank 1 while reading bank 0
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), b1[i], i == 3);
      rd_en = 1; rd_addr = 2'(i);
      tick();
      chk("fill1.rd_data", data_out, pat(b0[i]));
    end
    idle();
    chk("both.banks_ready", 128'(banks_ready), 128'd2);
    chk("both.wr_ready", 128'(wr_ready), 128'd0);
    chk("both.err_before", 128'(err_sticky), 128'd0);
    wr(2'd0, 8'hFF, 1'b0);
    tick();
    idle();
    chk("blocked.err", 128'(err_sticky), 128'd1);
    chk("blocked.banks_ready", 128'(banks_ready), 128'd2);

    // Read + release on the same cycle
    rd_en = 1; rd_release = 1; rd_addr = 3;
    tick();
    chk("rdrel.data", data_out, pat(8'h44));
    chk("rdrel.dov", 128'(data_out_valid), 128'd1);
    chk("rdrel.banks_ready", 128'(banks_ready), 128'd1);
    chk("rdrel.rd_bank_valid", 128'(rd_bank_valid), 128'd1);
    chk("rdrel.wr_ready", 128'(wr_ready), 128'd1);
    rd_release = 0; rd_addr = 0;
    tick();
    chk("bank1.rd0_unchanged", data_out, pat(8'h55));

    // Partial fill of bank 0 plus a read of bank 1, then reset mid-cycle
    wr(2'd0, 8'hAA, 1'b0);
    tick();
    wr(2'd1, 8'hBB, 1'b0);
    rd_en = 1; rd_addr = 1;
    tick();
    idle();
    chk("midfill.rd", data_out, pat(8'h66));
    chk("midfill.banks_ready", 128'(banks_ready), 128'd1);
    #2;
    rstn = 0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rstn = 1;
    tick();

    // Read of an unfilled bank after reset
    rd_en = 1; rd_addr = 0;
    chk("nofill.rd_bank_valid", 128'(rd_bank_valid), 128'd0);
    tick();
    idle();
    chk("nofill.err", 128'(err_sticky), 128'd1);
    chk("nofill.dov", 128'(data_out_valid), 128'd0);

    // Single-write fill FREE->READY, and memory cleared by reset
    wr(2'd2, 8'h99, 1'b1);
    tick();
    idle();
    chk("single.banks_ready", 128'(banks_ready), 128'd1);
    rd_en = 1; rd_addr = 2;
    tick();
    chk("single.rd2", data_out, pat(8'h99));
    rd_addr = 0;
    tick();
    chk("single.rd0_cleared", data_out, 128'd0);
    chk("single.rd0_dov", 128'(data_out_valid), 128'd1);

    // Write to bank 1 (last) while releasing bank 0
    idle();
    wr(2'd0, 8'hCC, 1'b1);
    rd_release = 1;
    tick();
    idle();
    chk("wrrel.banks_ready", 128'(banks_ready), 128'd1);
    chk("wrrel.rd_bank_valid", 128'(rd_bank_valid), 128'd1);
    chk("wrrel.wr_ready", 128'(wr_ready), 128'd1);
    rd_en = 1; rd_addr = 0;
    tick();
    chk("wrrel.rd", data_out, pat(8'hCC));
    chk("wrrel.perr", 128'(parity_err), 128'd0);

`ifdef PINGPONG_BUF_PARITY_EN
    idle();
    dut.g_bank[1].u_bank.mem[0] = dut.g_bank[1].u_bank.mem[0] ^ 128'h1;
    rd_en = 1; rd_addr = 0;
    tick();
    chk("par.flip_err", 128'(parity_err), 128'd1);
    chk("par.flip_dov", 128'(data_out_valid), 128'd1);
    rd_addr = 1;
    tick();
    chk("par.clean_err", 128'(parity_err), 128'd0);
`endif

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
